counter_ctrl: RTL
=================

# counter_ctrl

Sequencing controller for the loadable up-counter `counterfunc`. It turns a start/stop/hold command interface and a programmed period into the counter's `load`, `enab` and `cnt_in` controls, detects the terminal count and raises a one-cycle `done`. It supports one-shot and auto-reload operation. The block sits between the software-visible control registers and the counter datapath, and owns the counter instance.

## Interface
- `WIDTH`, default 5: counter and period width in bits.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  start request, sampled in IDLE only
- `stop`  in  1  abort request, sampled in RUN
- `hold`  in  1  pause counting while in RUN
- `auto_reload`  in  1  mode, captured together with `start`; 1 = periodic, 0 = one-shot
- `period`  in  WIDTH  terminal count P, captured together with `start`
- `count`  out  WIDTH  current counter value (`cnt_out` of the instance)
- `busy`  out  1  high while state is RUN
- `done`  out  1  one-cycle terminal-count pulse
- `err`  out  1  one-cycle pulse when `start` arrives with `period == 0`

## Operation
- **States:** IDLE and RUN.
- **Captured registers:** `period_q` and `mode_q`.
- **Counter drive:**
  - Counter `rst` is tied to block `rst`.
  - Counter `cnt_in` is always 0.
  - Inside the counter, `rst` beats `load`, and `load` beats `enab`.
  - The counter increments modulo 2^WIDTH.
- **IDLE:**
  - `load = 0`, `enab = 0`, so `count` holds its last value.
  - If `start` and `period != 0`: capture `period_q` and `mode_q`, assert `load` (count becomes 0), go to RUN.
  - If `start` and `period == 0`: pulse `err`, stay in IDLE, captured registers unchanged.
- **RUN, conditions evaluated in this priority order:**
  1. `stop`: go to IDLE, `enab = 0`, count frozen, no `done`.
  2. `hold`: stay in RUN, `enab = 0`, no terminal evaluation, `done = 0`.
  3. `count == period_q` (terminal): `done = 1`, `enab = 0`.
     - If `mode_q = 1`: `load = 1` (count becomes 0), stay in RUN.
     - Else: go to IDLE, count holds P.
  4. Otherwise: `enab = 1` (increment).
- **Ignored inputs:**
  - `start` in RUN is ignored.
  - `period` and `auto_reload` changes after capture have no effect until the next start.
- **Outputs:**
  - `done = (state == RUN) && !stop && !hold && (count == period_q)`, decoded from registered state only, with no input-to-output path other than `stop`/`hold` gating.
  - `busy = (state == RUN)`.
- **Width rules:**
  - P ranges over 1..2^WIDTH−1.
  - Count never exceeds `period_q`, so the counter's modulo wrap is never exercised in RUN.
  - P = 2^WIDTH−1 is legal and must terminate at all-ones.
- **Reset values:** state IDLE, `count` 0, `period_q` 0, `mode_q` 0, `busy` 0, `done` 0, `err` 0. Reset mid-RUN aborts immediately and no `done` is produced.

## Timing
- `start` accepted at edge N: after N, `busy = 1` and `count = 0`.
- Without hold, after edge N+k, `count = k`.
- `done` is high for the single cycle after edge N+P.
- One-shot: after edge N+P+1, `busy = 0` and `count = P`.
- Auto-reload:
  - `count = 0` again after edge N+P+1.
  - Period is P+1 cycles, and `done` repeats every P+1 cycles.
- Each hold cycle extends the interval by exactly one cycle.
- `stop` takes effect at the next edge: `busy` falls and `count` is frozen.
- `err` is high for exactly the cycle following the rejected start.
- The earliest restart is the first cycle after returning to IDLE.

## Structure
- Shared package `counter_pkg` holds:
  - the state encoding constants `ST_IDLE` and `ST_RUN`;
  - the default width constant `CNT_WIDTH_DEF = 5`.
- One sub-module: the existing `counterfunc #(.WIDTH(WIDTH))`, instantiated as `counter_inst`. Its ports `clk, rst, load, enab, cnt_in, cnt_out` are driven as above.
- The FSM, capture registers and terminal compare live in `counter_ctrl`.
- `err` is a registered pulse.

## Test plan
All scenarios use WIDTH=5.
1. **Reset:** `rst = 1` for 2 cycles with `start = 1` -> `count = 0`, `busy = 0`, `done = 0`, `err = 0`. After release, the first `start` is honoured.
2. **One-shot:** `period = 3`, `auto_reload = 0`, one-cycle `start` -> `count` 0,1,2,3; `done` only in the `count = 3` cycle; then `busy = 0` and `count` holds 3 for 5 further cycles.
3. **Auto-reload:** `period = 2`, `auto_reload = 1` -> `count` 0,1,2,0,1,2,0; `done` every 3rd cycle. A `start` with `period = 7` mid-run is ignored.
4. **Hold and stop:** `period = 4`; `hold` for 2 cycles at `count = 2` -> `count` stays 2 and `done` is delayed by 2 cycles. In a second run, `stop` at `count = 3` -> IDLE, `count = 3`, no `done`.
5. **Boundaries:**
   - `start` with `period = 0` -> `err` pulse, `busy` stays 0.
   - `period = 5'h1F` one-shot -> `done` at `count = 1F`, and `count` never wraps to 0.
   - `stop` and terminal in the same cycle -> `done = 0`.
6. **Reset mid-run:** `period = 6`, `rst` asserted at `count = 4` -> next cycle `count = 0`, `busy = 0`, no `done`; a subsequent `start` runs normally.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencing controller.
package counter_pkg;

  localparam int CNT_WIDTH_DEF = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/counterfunc.sv
// Loadable up-counter: rst beats load, load beats enab, wraps modulo 2^WIDTH.
module counterfunc
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  always_ff @(posedge clk) begin
    if (rst)       cnt_out <= '0;
    else if (load) cnt_out <= cnt_in;
    else if (enab) cnt_out <= cnt_out + 1'b1;
  end

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/hold sequencer around counterfunc with one-shot and auto-reload modes.
//   state   | meaning
//   ST_IDLE | counter frozen, waiting for a start with a non-zero period
//   ST_RUN  | counting toward period_q; done pulses at the terminal count
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, state_n;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic             capture;
  logic             err_n;
  logic             load;
  logic             enab;
  logic [WIDTH-1:0] cnt_in;

  assign cnt_in = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      err   <= err_n;
      if (capture) begin
        period_q <= period;
        mode_q   <= auto_reload;
      end
    end
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    enab    = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (period != '0) begin
            capture = 1'b1;
            load    = 1'b1;
            state_n = ST_RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // stop outranks hold, which outranks the terminal compare
        if (stop) begin
          state_n = ST_IDLE;
        end else if (hold) begin
          state_n = ST_RUN;
        end else if (count == period_q) begin
          done = 1'b1;
          if (mode_q) load = 1'b1;
          else        state_n = ST_IDLE;
        end else begin
          enab = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);

  counterfunc #(.WIDTH(WIDTH)) counter_inst (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enab    (enab),
    .cnt_in  (cnt_in),
    .cnt_out (count)
  );

endmodule
